// File: rtl/alarm_output_driver.sv
// Buzzer tone/cadence generator with ring timeout and display blink enable.
// Optional snooze pause is built only when ALARM_SNOOZE_EN is defined.
module alarm_output_driver #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TONE_HZ     = 2_000,
  parameter int unsigned BEEP_ON_MS  = 250,
  parameter int unsigned BEEP_OFF_MS = 250,
  parameter int unsigned FLASH_HZ    = 2,
  parameter int unsigned TIMEOUT_S   = 60,
  parameter int unsigned SNOOZE_S    = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic buzzer_on,
  input  logic display_flash,
  input  logic snooze,
  output logic buzzer,
  output logic display_on,
  output logic ringing
);

  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned MsDiv     = at_least_one(CLK_HZ / 1000);
  localparam int unsigned ToneHalf  = at_least_one(CLK_HZ / (2 * TONE_HZ));
  localparam int unsigned FlashHalf = at_least_one(CLK_HZ / (2 * FLASH_HZ));
  localparam int unsigned BeepOn    = at_least_one(BEEP_ON_MS);
  localparam int unsigned BeepOff   = at_least_one(BEEP_OFF_MS);
  localparam int unsigned RingMs    = at_least_one(TIMEOUT_S * 1000);
  localparam int unsigned CadMax    = (BeepOn > BeepOff) ? BeepOn : BeepOff;

  localparam int unsigned MsW    = cnt_width(MsDiv);
  localparam int unsigned ToneW  = cnt_width(ToneHalf);
  localparam int unsigned FlashW = cnt_width(FlashHalf);
  localparam int unsigned CadW   = cnt_width(CadMax);
  localparam int unsigned RingW  = cnt_width(RingMs);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StBeep   = 3'd1;
  localparam logic [2:0] StGap    = 3'd2;
  localparam logic [2:0] StMuted  = 3'd3;
`ifdef ALARM_SNOOZE_EN
  localparam logic [2:0] StSnooze = 3'd4;
  localparam int unsigned SnoozeMs = at_least_one(SNOOZE_S * 1000);
  localparam int unsigned SnzW     = cnt_width(SnoozeMs);
  logic [SnzW-1:0] snz_q, snz_d;
`else
  logic unused_snooze;
  assign unused_snooze = snooze ^ (SNOOZE_S == 0);
`endif

  logic [2:0]        state_q, state_d;
  logic [MsW-1:0]    ms_q, ms_d;
  logic [ToneW-1:0]  tone_q, tone_d;
  logic [CadW-1:0]   cad_q, cad_d;
  logic [RingW-1:0]  ring_q, ring_d;
  logic [FlashW-1:0] flash_q, flash_d;
  logic              buzzer_q, buzzer_d;
  logic              display_q, display_d;
  logic              ringing_q, ringing_d;
  logic              flash_prev_q;
  logic              active, ms_tick;

  // The ms prescaler only runs while a ring (or snooze) is in progress.
`ifdef ALARM_SNOOZE_EN
  assign active = (state_q == StBeep) || (state_q == StGap) || (state_q == StSnooze);
`else
  assign active = (state_q == StBeep) || (state_q == StGap);
`endif
  assign ms_tick = (ms_q == MsW'(MsDiv - 1));
  assign ms_d    = (active && !ms_tick) ? ms_q + MsW'(1) : '0;

  always_comb begin
    state_d  = state_q;
    tone_d   = tone_q;
    cad_d    = cad_q;
    ring_d   = ring_q;
    buzzer_d = buzzer_q;
`ifdef ALARM_SNOOZE_EN
    snz_d    = snz_q;
`endif
    if (!buzzer_on) begin
      state_d  = StIdle;
      tone_d   = '0;
      cad_d    = '0;
      ring_d   = '0;
      buzzer_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_d    = '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          state_d  = StBeep;
          buzzer_d = 1'b1;
          tone_d   = '0;
          cad_d    = '0;
          ring_d   = '0;
        end
        StBeep, StGap: begin
          if (ms_tick && (ring_q == RingW'(RingMs - 1))) begin
            state_d  = StMuted;
            buzzer_d = 1'b0;
            tone_d   = '0;
            cad_d    = '0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze) begin
            state_d  = StSnooze;
            buzzer_d = 1'b0;
            tone_d   = '0;
            cad_d    = '0;
            snz_d    = '0;
          end
`endif
          else begin
            if (ms_tick) ring_d = ring_q + RingW'(1);
            if (state_q == StBeep) begin
              if (ms_tick && (cad_q == CadW'(BeepOn - 1))) begin
                state_d  = StGap;
                buzzer_d = 1'b0;
                tone_d   = '0;
                cad_d    = '0;
              end else begin
                if (ms_tick) cad_d = cad_q + CadW'(1);
                if (tone_q == ToneW'(ToneHalf - 1)) begin
                  buzzer_d = ~buzzer_q;
                  tone_d   = '0;
                end else begin
                  tone_d = tone_q + ToneW'(1);
                end
              end
            end else if (ms_tick && (cad_q == CadW'(BeepOff - 1))) begin
              state_d  = StBeep;
              buzzer_d = 1'b1;
              tone_d   = '0;
              cad_d    = '0;
            end else if (ms_tick) begin
              cad_d = cad_q + CadW'(1);
            end
          end
        end
        StMuted: buzzer_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
        StSnooze: begin
          if (snooze) begin
            snz_d = '0;
          end else if (ms_tick) begin
            if (snz_q == SnzW'(SnoozeMs - 1)) begin
              state_d  = StBeep;
              buzzer_d = 1'b1;
              tone_d   = '0;
              cad_d    = '0;
              snz_d    = '0;
            end else begin
              snz_d = snz_q + SnzW'(1);
            end
          end
        end
`endif
        default: begin
          state_d  = StIdle;
          buzzer_d = 1'b0;
        end
      endcase
    end
    ringing_d = (state_d == StBeep) || (state_d == StGap);
  end

  // Blink runs purely off display_flash; a fresh request always starts lit.
  always_comb begin
    display_d = display_q;
    flash_d   = flash_q;
    if (!display_flash || !flash_prev_q) begin
      display_d = 1'b1;
      flash_d   = '0;
    end else if (flash_q == FlashW'(FlashHalf - 1)) begin
      display_d = ~display_q;
      flash_d   = '0;
    end else begin
      flash_d = flash_q + FlashW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ms_q         <= '0;
      tone_q       <= '0;
      cad_q        <= '0;
      ring_q       <= '0;
      flash_q      <= '0;
      buzzer_q     <= 1'b0;
      display_q    <= 1'b1;
      ringing_q    <= 1'b0;
      flash_prev_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ms_q         <= ms_d;
      tone_q       <= tone_d;
      cad_q        <= cad_d;
      ring_q       <= ring_d;
      flash_q      <= flash_d;
      buzzer_q     <= buzzer_d;
      display_q    <= display_d;
      ringing_q    <= ringing_d;
      flash_prev_q <= display_flash;
`ifdef ALARM_SNOOZE_EN
      snz_q        <= snz_d;
`endif
    end
  end

  assign buzzer     = buzzer_q;
  assign display_on = display_q;
  assign ringing    = ringing_q;

endmodule

// File: tb/tb_alarm_output_driver.sv
// Directed bench for alarm_output_driver using the scaled-down timing set
// (ms tick = 1 cycle, tone half = 5, flash half = 10, timeout = 1000 ticks).
module tb_alarm_output_driver;

  logic clk = 1'b0;
  logic reset, buzzer_on, display_flash, snooze;
  logic buzzer, display_on, ringing;
  int   vectors = 0;
  int   miscompares = 0;

  alarm_output_driver #(
    .CLK_HZ     (1000),
    .TONE_HZ    (100),
    .BEEP_ON_MS (20),
    .BEEP_OFF_MS(10),
    .FLASH_HZ   (50),
    .TIMEOUT_S  (1),
    .SNOOZE_S   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .buzzer_on    (buzzer_on),
    .display_flash(display_flash),
    .snooze       (snooze),
    .buzzer       (buzzer),
    .display_on   (display_on),
    .ringing      (ringing)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // k = cycles since the edge that started the ring (k=1 is the first BEEP cycle).
  function automatic logic beep_model(input int k);
    int ph;
    ph = (k - 1) % 30;
    return (ph < 20) && (((ph / 5) % 2) == 0);
  endfunction

  initial begin
    reset = 1'b1; buzzer_on = 1'b1; display_flash = 1'b0; snooze = 1'b0;
    step();
    step();
    check("rst_buzzer", buzzer, 1'b0);
    check("rst_display", display_on, 1'b1);
    check("rst_ringing", ringing, 1'b0);

    // Cadence through to auto-mute.
    reset = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      step();
      check($sformatf("buzzer@%0d", k), buzzer, beep_model(k));
      check($sformatf("ringing@%0d", k), ringing, 1'b1);
    end
    step();
    check("muted_buzzer", buzzer, 1'b0);
    check("muted_ringing", ringing, 1'b0);
    repeat (199) step();
    check("muted_hold_buzzer", buzzer, 1'b0);
    check("muted_hold_ringing", ringing, 1'b0);

    // Re-arm after mute.
    buzzer_on = 1'b0;
    step();
    check("idle_ringing", ringing, 1'b0);
    buzzer_on = 1'b1;
    step();
    check("rearm_ringing", ringing, 1'b1);
    check("rearm_buzzer", buzzer, 1'b1);

    // Drop request mid tone half-period.
    step();
    step();
    check("mid_tone_buzzer", buzzer, 1'b1);
    buzzer_on = 1'b0;
    step();
    check("drop_buzzer", buzzer, 1'b0);
    check("drop_ringing", ringing, 1'b0);

    // Display blink for 45 cycles.
    display_flash = 1'b1;
    for (int j = 1; j <= 45; j++) begin
      step();
      check($sformatf("display@%0d", j), display_on, ((((j - 1) / 10) % 2) == 0));
    end
    display_flash = 1'b0;
    step();
    check("display_release", display_on, 1'b1);

    // Snooze pulse mid-BEEP.
    buzzer_on = 1'b1;
    step();
    step();
    step();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
    check("snooze_ringing", ringing, 1'b0);
    check("snooze_buzzer@4", buzzer, 1'b0);
    for (int k = 5; k <= 1003; k++) begin
      step();
      check($sformatf("snooze_buzzer@%0d", k), buzzer, 1'b0);
    end
    step();
    check("snooze_end_buzzer", buzzer, 1'b1);
    check("snooze_end_ringing", ringing, 1'b1);
`else
    check("snooze_ignored_ringing", ringing, 1'b1);
    check("snooze_ignored_buzzer@4", buzzer, beep_model(4));
    for (int k = 5; k <= 40; k++) begin
      step();
      check($sformatf("snooze_ignored_buzzer@%0d", k), buzzer, beep_model(k));
    end
`endif

    // Asynchronous reset mid-ring with the display dark.
    buzzer_on = 1'b0;
    step();
    buzzer_on = 1'b1;
    display_flash = 1'b1;
    repeat (12) step();
    check("pre_rst_buzzer", buzzer, 1'b1);
    check("pre_rst_display", display_on, 1'b0);
    check("pre_rst_ringing", ringing, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_buzzer", buzzer, 1'b0);
    check("async_rst_display", display_on, 1'b1);
    check("async_rst_ringing", ringing, 1'b0);
    display_flash = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("post_rst_ringing", ringing, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
